turn_sequencer: RTL and testbench
=================================

# turn_sequencer

Registered game-flow controller that generates the shared 3-bit `state` bus consumed by `p1handed` and `p2handed`. It sequences a two-player hide-and-guess round: P1 hides a token in the left or right hand, P2 guesses, then the round is scored. It captures player button presses, enforces a per-turn timeout and keeps scores until one player reaches `WIN_SCORE`.

## Interface
- `TIMEOUT_CYC`, default 1000: cycles a player may idle in a turn state before forfeiting the round.
- `WIN_SCORE`, default 3: score that ends the game.
- `SCORE_W`, default 3: score counter width; must satisfy 2^SCORE_W > WIN_SCORE.
- `clk`  in  1  system clock; all flops rise-edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  level input; rising edge starts or restarts a game.
- `p1_btn`  in  2  P1 hand buttons, one bit per hand: [0]=left, [1]=right.
- `p2_btn`  in  2  P2 hand buttons, one bit per hand: [0]=left guess, [1]=right guess.
- `state`  out  3  current FSM state, driven directly from flops.
- `p1_hide`  out  1  registered hide choice of P1 (0 = left).
- `p2_guess`  out  1  registered guess of P2.
- `p1_score`, `p2_score`  out  SCORE_W  running scores.
- `winner`  out  2  00 = none, 01 = P1, 10 = P2.

## Operation
- State encodings:
  - IDLE = 000
  - ROUND_START = 001
  - P1_TURN = 010
  - P1_HANDED = 011
  - P2_TURN = 110
  - P2_HANDED = 100
  - RESOLVE = 101
  - GAME_OVER = 111
- Transitions:
  - IDLE → ROUND_START on `start` rising edge; scores are cleared.
  - ROUND_START → P1_TURN unconditionally (1 cycle).
  - P1_TURN → P1_HANDED on a valid P1 press; `p1_hide` latches the pressed bit index.
  - P1_HANDED → P2_TURN unconditionally.
  - P2_TURN → P2_HANDED on a valid P2 press; `p2_guess` latches the pressed bit index.
  - P2_HANDED → RESOLVE unconditionally.
  - RESOLVE → GAME_OVER if the updated score equals WIN_SCORE, otherwise → ROUND_START.
  - GAME_OVER → ROUND_START on `start` rising edge; scores and `winner` are cleared.
- Valid press: rising edge of exactly one bit of the player's 2-bit bus.
  - An edge on both bits in the same cycle is ignored.
  - An edge on one bit while the other bit is held high is valid.
  - Presses outside that player's turn state are ignored and are not queued.
- Scoring is applied in RESOLVE: `p2_guess == p1_hide` gives P2 +1, otherwise P1 +1.
- Timeout: a counter clears on entry to P1_TURN or P2_TURN and increments each cycle in that state.
  - When it reaches TIMEOUT_CYC-1 with no valid press, the FSM goes directly to RESOLVE.
  - The opponent of the idle player scores; the normal hide/guess comparison is skipped.
- `winner` is set on entry to GAME_OVER.
- `start` edges outside IDLE and GAME_OVER are ignored.
- Downstream `p1handed` and `p2handed` derive their clocks from `state`. Two rules are mandatory:
  - `state` must be glitch-free (pure flop outputs, no combinational decode).
  - ROUND_START must never be adjacent to P1_HANDED or P2_HANDED, so each of those states is entered with a real edge.

## Timing
- Reset (`reset_n`=0 at a clk edge):
  - `state`=000, scores=0, `winner`=00, `p1_hide`=0, `p2_guess`=0.
  - Timeout counter and button edge history are cleared.
  - Reset applied mid-round aborts the round with no score update.
- Edge detection uses one history register per bus, so a press sampled at edge N moves the state at edge N+1.
- Single-cycle states: ROUND_START, P1_HANDED, P2_HANDED, RESOLVE.
- Minimum round length with immediate presses is 6 cycles.
- Score and `winner` update at the same edge that leaves RESOLVE.
- A press in the same cycle the timeout expires wins: the press is taken and the timeout is discarded.

## Structure
- Shared package `game_pkg` holds:
  - the `state_t` 3-bit enum with the encodings above;
  - the `WINNER_*` constants.
- `p1handed` and `p2handed` must use the same encodings.
- Sub-module `btn_edge`:
  - 2-bit rising-edge detect plus exactly-one-hot check;
  - outputs `press_vld` and `press_idx`;
  - instantiated once per player.
- Timeout counter width is $clog2(TIMEOUT_CYC).

## Test plan
- Reset with `start`=1 held: `state` stays 000. Release and re-assert `start`: `state` 001 next edge, then 010.
- P1 press `p1_btn`=01, then P2 press `p2_btn`=01: state sequence 010→011→110→100→101→001, `p2_score`=1, `p1_score`=0.
- P1 presses right (10), P2 guesses left (01) three times with WIN_SCORE=3: `p1_score`=3, `state`=111, `winner`=01.
- TIMEOUT_CYC=8, no P1 press in P1_TURN: RESOLVE after 8 cycles in P1_TURN, `p2_score` +1.
- `p1_btn`=11 rising together: no transition. Then `p1_btn`=01 while in P2_TURN: ignored, `state` holds 110.
- `reset_n` low during P2_TURN with scores 2/1: next edge `state`=000 and both scores 0.

Source files
------------

// File: rtl/game_pkg.sv
// Shared encodings for the hide-and-guess game: FSM state bus, winner codes
// and the press-qualification helper used by the button edge detectors.
package game_pkg;

    // ROUND_START (001) differs from P1_HANDED (011) and P2_HANDED (100) so those
    // states are always entered with a real edge on the state bus.
    typedef enum logic [2:0] {
        IDLE        = 3'b000,
        ROUND_START = 3'b001,
        P1_TURN     = 3'b010,
        P1_HANDED   = 3'b011,
        P2_TURN     = 3'b110,
        P2_HANDED   = 3'b100,
        RESOLVE     = 3'b101,
        GAME_OVER   = 3'b111
    } state_t;

    localparam logic [1:0] WINNER_NONE = 2'b00;
    localparam logic [1:0] WINNER_P1   = 2'b01;
    localparam logic [1:0] WINNER_P2   = 2'b10;

    // Records which player, if any, let the turn timer run out this round.
    typedef enum logic [1:0] {
        FORFEIT_NONE = 2'b00,
        FORFEIT_P1   = 2'b01,
        FORFEIT_P2   = 2'b10
    } forfeit_t;

    function automatic logic single_hot2(input logic [1:0] v);
        return v[0] ^ v[1];
    endfunction

endpackage

// File: rtl/turn_sequencer_if.sv
// Player-facing bus of the turn sequencer: start/buttons in, game status out.
interface turn_sequencer_if #(
    parameter int SCORE_W = 3
);
    import game_pkg::*;

    // Protocol: there is no valid/ready pair. start is edge-triggered (0->1) and
    // only honoured in IDLE or GAME_OVER; a player press is a 0->1 edge on
    // exactly one bit of that player's button pair, honoured only in that
    // player's turn state and otherwise dropped without being remembered.
    logic               start;
    logic [1:0]         p1_btn;
    logic [1:0]         p2_btn;
    state_t             state;
    logic               p1_hide;
    logic               p2_guess;
    logic [SCORE_W-1:0] p1_score;
    logic [SCORE_W-1:0] p2_score;
    logic [1:0]         winner;

    modport master (
        output start, p1_btn, p2_btn,
        input  state, p1_hide, p2_guess, p1_score, p2_score, winner
    );

    modport slave (
        input  start, p1_btn, p2_btn,
        output state, p1_hide, p2_guess, p1_score, p2_score, winner
    );

endinterface

// File: rtl/btn_edge.sv
// Rising-edge detector for one player's two hand buttons; a press is valid
// only when exactly one bit rises in a cycle.
module btn_edge
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] btn,
    output logic       press_vld,
    output logic       press_idx
);

    logic [1:0] hist_q;
    logic [1:0] hist_d;
    logic [1:0] rise;

    // A rise on one bit while the other is already held high still counts.
    always_comb begin
        hist_d    = btn;
        rise      = btn & ~hist_q;
        press_vld = single_hot2(rise);
        press_idx = rise[1];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hist_q <= 2'b00;
        end else begin
            hist_q <= hist_d;
        end
    end

endmodule

// File: rtl/turn_sequencer.sv
// Game-flow FSM for the two-player hide-and-guess round: captures presses,
// enforces the per-turn timeout and keeps score until WIN_SCORE is reached.
module turn_sequencer
    import game_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1000,
    parameter int WIN_SCORE   = 3,
    parameter int SCORE_W     = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    turn_sequencer_if.slave  bus
);

    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0]    TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [SCORE_W-1:0] WIN_VAL = SCORE_W'(WIN_SCORE);

    state_t             state_q, state_d;
    logic               start_prev_q, start_prev_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    forfeit_t           forfeit_q, forfeit_d;
    logic               p1_hide_q, p1_hide_d;
    logic               p2_guess_q, p2_guess_d;
    logic [SCORE_W-1:0] p1_score_q, p1_score_d;
    logic [SCORE_W-1:0] p2_score_q, p2_score_d;
    logic [1:0]         winner_q, winner_d;

    logic               p1_vld, p1_idx;
    logic               p2_vld, p2_idx;
    logic               start_rise;
    logic               p2_point;
    logic [SCORE_W-1:0] p1_next;
    logic [SCORE_W-1:0] p2_next;

    btn_edge u_p1_edge (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn       (bus.p1_btn),
        .press_vld (p1_vld),
        .press_idx (p1_idx)
    );

    btn_edge u_p2_edge (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn       (bus.p2_btn),
        .press_vld (p2_vld),
        .press_idx (p2_idx)
    );

    always_comb begin
        state_d      = state_q;
        start_prev_d = bus.start;
        to_cnt_d     = to_cnt_q;
        forfeit_d    = forfeit_q;
        p1_hide_d    = p1_hide_q;
        p2_guess_d   = p2_guess_q;
        p1_score_d   = p1_score_q;
        p2_score_d   = p2_score_q;
        winner_d     = winner_q;
        start_rise   = bus.start & ~start_prev_q;
        p1_next      = p1_score_q + SCORE_W'(1);
        p2_next      = p2_score_q + SCORE_W'(1);
        // A timeout hands the point to the opponent; otherwise a correct guess scores for P2.
        p2_point     = (forfeit_q == FORFEIT_P1) ||
                       ((forfeit_q == FORFEIT_NONE) && (p2_guess_q == p1_hide_q));

        case (state_q)
            IDLE: begin
                if (start_rise) begin
                    state_d    = ROUND_START;
                    p1_score_d = '0;
                    p2_score_d = '0;
                end
            end
            ROUND_START: begin
                state_d   = P1_TURN;
                to_cnt_d  = '0;
                forfeit_d = FORFEIT_NONE;
            end
            P1_TURN: begin
                // A press on the expiry cycle takes priority over the timeout.
                if (p1_vld) begin
                    state_d   = P1_HANDED;
                    p1_hide_d = p1_idx;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d   = RESOLVE;
                    forfeit_d = FORFEIT_P1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            P1_HANDED: begin
                state_d  = P2_TURN;
                to_cnt_d = '0;
            end
            P2_TURN: begin
                if (p2_vld) begin
                    state_d    = P2_HANDED;
                    p2_guess_d = p2_idx;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d   = RESOLVE;
                    forfeit_d = FORFEIT_P2;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            P2_HANDED: begin
                state_d = RESOLVE;
            end
            RESOLVE: begin
                if (p2_point) begin
                    p2_score_d = p2_next;
                    if (p2_next == WIN_VAL) begin
                        state_d  = GAME_OVER;
                        winner_d = WINNER_P2;
                    end else begin
                        state_d = ROUND_START;
                    end
                end else begin
                    p1_score_d = p1_next;
                    if (p1_next == WIN_VAL) begin
                        state_d  = GAME_OVER;
                        winner_d = WINNER_P1;
                    end else begin
                        state_d = ROUND_START;
                    end
                end
            end
            GAME_OVER: begin
                if (start_rise) begin
                    state_d    = ROUND_START;
                    p1_score_d = '0;
                    p2_score_d = '0;
                    winner_d   = WINNER_NONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // start history keeps sampling through reset so a start held across reset
    // release is not mistaken for a new edge.
    always_ff @(posedge clk) begin
        start_prev_q <= start_prev_d;
        if (!reset_n) begin
            state_q    <= IDLE;
            to_cnt_q   <= '0;
            forfeit_q  <= FORFEIT_NONE;
            p1_hide_q  <= 1'b0;
            p2_guess_q <= 1'b0;
            p1_score_q <= '0;
            p2_score_q <= '0;
            winner_q   <= WINNER_NONE;
        end else begin
            state_q    <= state_d;
            to_cnt_q   <= to_cnt_d;
            forfeit_q  <= forfeit_d;
            p1_hide_q  <= p1_hide_d;
            p2_guess_q <= p2_guess_d;
            p1_score_q <= p1_score_d;
            p2_score_q <= p2_score_d;
            winner_q   <= winner_d;
        end
    end

    assign bus.state    = state_q;
    assign bus.p1_hide  = p1_hide_q;
    assign bus.p2_guess = p2_guess_q;
    assign bus.p1_score = p1_score_q;
    assign bus.p2_score = p2_score_q;
    assign bus.winner   = winner_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// Scoreboard bench for turn_sequencer: each driven cycle pushes the expected
// game status, which is popped and compared one edge later.
module tb_turn_sequencer;
    import game_pkg::*;

    localparam int TO  = 8;
    localparam int WIN = 3;
    localparam int SW  = 3;
    localparam int W   = 3 + SW + SW + 2 + 1 + 1;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    turn_sequencer_if #(.SCORE_W(SW)) bus ();

    turn_sequencer #(
        .TIMEOUT_CYC (TO),
        .WIN_SCORE   (WIN),
        .SCORE_W     (SW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [W-1:0] exp_q[$];
    int           n_vec = 0;
    int           n_err = 0;

    state_t       e_state;
    logic [SW-1:0] e_p1, e_p2;
    logic [1:0]   e_win;
    logic         e_hide, e_guess;

    task automatic check_vec(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got state=%b p1=%0d p2=%0d win=%b hide=%b guess=%b, expected state=%b p1=%0d p2=%0d win=%b hide=%b guess=%b",
                     tag, got[W-1 -: 3], got[W-4 -: SW], got[W-4-SW -: SW], got[3:2], got[1], got[0],
                     exp[W-1 -: 3], exp[W-4 -: SW], exp[W-4-SW -: SW], exp[3:2], exp[1], exp[0]);
        end
    endtask

    task automatic tick(input string tag);
        logic [W-1:0] e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty at t=%0t", tag, $time);
        end else begin
            e = exp_q.pop_front();
            check_vec(tag, {bus.state, bus.p1_score, bus.p2_score, bus.winner, bus.p1_hide, bus.p2_guess}, e);
        end
    endtask

    task automatic step(input state_t s, input string tag);
        e_state = s;
        exp_q.push_back({e_state, e_p1, e_p2, e_win, e_hide, e_guess});
        tick(tag);
    endtask

    // Starts from an observed ROUND_START and plays one round with immediate presses.
    task automatic play_round(input logic h, input logic g, input string tag);
        step(P1_TURN, tag);
        bus.p1_btn = h ? 2'b10 : 2'b01;
        e_hide = h;
        step(P1_HANDED, tag);
        bus.p1_btn = 2'b00;
        step(P2_TURN, tag);
        bus.p2_btn = g ? 2'b10 : 2'b01;
        e_guess = g;
        step(P2_HANDED, tag);
        bus.p2_btn = 2'b00;
        step(RESOLVE, tag);
        if (g == h) e_p2 = e_p2 + 1'b1;
        else        e_p1 = e_p1 + 1'b1;
        if (e_p1 == SW'(WIN)) begin
            e_win = WINNER_P1;
            step(GAME_OVER, tag);
        end else if (e_p2 == SW'(WIN)) begin
            e_win = WINNER_P2;
            step(GAME_OVER, tag);
        end else begin
            step(ROUND_START, tag);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start  = 1'b1;
        bus.p1_btn = 2'b00;
        bus.p2_btn = 2'b00;
        reset_n    = 1'b0;
        e_state    = IDLE;
        e_p1       = '0;
        e_p2       = '0;
        e_win      = WINNER_NONE;
        e_hide     = 1'b0;
        e_guess    = 1'b0;

        repeat (3) step(IDLE, "reset_start_held");
        reset_n = 1'b1;
        repeat (2) step(IDLE, "start_held_after_reset");
        bus.start = 1'b0;
        step(IDLE, "start_low");
        bus.start = 1'b1;
        step(ROUND_START, "start_edge");
        bus.start = 1'b0;

        play_round(1'b0, 1'b0, "round_p2_guesses");
        repeat (3) play_round(1'b1, 1'b0, "p1_streak");
        step(GAME_OVER, "game_over_hold");

        bus.start = 1'b1;
        e_p1  = '0;
        e_p2  = '0;
        e_win = WINNER_NONE;
        step(ROUND_START, "restart_clears");
        bus.start = 1'b0;

        // P1 idles (a double press does not count) until the turn times out.
        step(P1_TURN, "p1_turn_enter");
        bus.p1_btn = 2'b11;
        step(P1_TURN, "p1_double_press");
        repeat (6) step(P1_TURN, "p1_idle");
        bus.p1_btn = 2'b00;
        step(RESOLVE, "p1_timeout");
        e_p2 = e_p2 + 1'b1;
        step(ROUND_START, "p1_forfeit_score");

        // Off-turn presses are dropped; a rise beside a held bit is a valid guess.
        bus.p2_btn = 2'b01;
        step(P1_TURN, "p2_press_in_p1_turn");
        bus.p1_btn = 2'b01;
        e_hide = 1'b0;
        step(P1_HANDED, "p1_hide_left");
        bus.p1_btn = 2'b00;
        step(P2_TURN, "p2_turn_enter");
        bus.p1_btn = 2'b01;
        step(P2_TURN, "p1_press_in_p2_turn");
        step(P2_TURN, "p1_press_not_queued");
        bus.p2_btn = 2'b11;
        e_guess = 1'b1;
        step(P2_HANDED, "held_bit_press");
        bus.p1_btn = 2'b00;
        bus.p2_btn = 2'b00;
        step(RESOLVE, "resolve_miss");
        e_p1 = e_p1 + 1'b1;
        step(ROUND_START, "p1_scores_on_miss");

        // P2 idles through the whole turn.
        step(P1_TURN, "p2_to_round");
        bus.p1_btn = 2'b10;
        e_hide = 1'b1;
        step(P1_HANDED, "p1_hide_right");
        bus.p1_btn = 2'b00;
        repeat (8) step(P2_TURN, "p2_idle");
        step(RESOLVE, "p2_timeout");
        e_p1 = e_p1 + 1'b1;
        step(ROUND_START, "p2_forfeit_score");

        // Reset mid-round with scores 2/1 aborts the round.
        step(P1_TURN, "abort_round");
        bus.p1_btn = 2'b01;
        e_hide = 1'b0;
        step(P1_HANDED, "abort_round_hide");
        bus.p1_btn = 2'b00;
        step(P2_TURN, "abort_round_p2");
        reset_n = 1'b0;
        e_p1    = '0;
        e_p2    = '0;
        e_win   = WINNER_NONE;
        e_hide  = 1'b0;
        e_guess = 1'b0;
        step(IDLE, "reset_mid_round");
        reset_n = 1'b1;
        step(IDLE, "idle_after_reset");

        // A press on the last timeout cycle is accepted.
        bus.start = 1'b1;
        step(ROUND_START, "start_after_reset");
        bus.start = 1'b0;
        repeat (8) step(P1_TURN, "p1_wait_to_last");
        bus.p1_btn = 2'b10;
        e_hide = 1'b1;
        step(P1_HANDED, "press_beats_timeout");
        bus.p1_btn = 2'b00;
        step(P2_TURN, "p2_turn_after_late_press");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
